// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM byte arbiter.
// State encoding, lane geometry and timeout counter width.
package sdram_arb_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = LANE_W * LANES;
  localparam int TO_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    ACK
  } state_t;

endpackage

// File: rtl/sdram_byte_lane.sv
// Byte lane extract and merge for a 32-bit SDRAM word.
// Lane n occupies word bits [8n+7:8n].
module sdram_byte_lane
  import sdram_arb_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        lane_i,
  input  logic [LANE_W-1:0] byte_i,
  output logic [LANE_W-1:0] byte_o,
  output logic [WORD_W-1:0] word_o
);

  // select one lane for extract, replace it for merge
  always_comb begin
    byte_o = '0;
    word_o = word_i;
    for (int n = 0; n < LANES; n++) begin
      if (lane_i == 2'(n)) begin
        byte_o = word_i[n*LANE_W +: LANE_W];
        word_o[n*LANE_W +: LANE_W] = byte_i;
      end
    end
  end

endmodule

// File: rtl/sdram_byte_arbiter.sv
// Two-client byte access arbiter over a word-wide SDRAM controller.
// Define SDRAM_ARB_RR_EN for round-robin; default is fixed priority.
module sdram_byte_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int RD_TIMEOUT = 255
) (
  input  logic              sdram_clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [23:0]       c0_addr,
  input  logic [7:0]        c0_wdata,
  output logic [7:0]        c0_rdata,
  output logic              c0_ack,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [23:0]       c1_addr,
  input  logic [7:0]        c1_wdata,
  output logic [7:0]        c1_rdata,
  output logic              c1_ack,
  output logic [21:0]       ctl_addr,
  output logic              ctl_rw,
  output logic [31:0]       ctl_wdata,
  output logic              ctl_in_valid,
  input  logic              ctl_busy,
  input  logic [31:0]       ctl_rdata,
  input  logic              ctl_out_valid,
  output logic              err
);

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [23:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] wword_q, wword_d;
  logic              cap_q, cap_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [7:0]        rd0_q, rd0_d;
  logic [7:0]        rd1_q, rd1_d;
  logic              pick;
  logic [LANE_W-1:0] lane_byte;
  logic [WORD_W-1:0] lane_word;

  sdram_byte_lane u_lane (
    .word_i (word_q),
    .lane_i (addr_q[1:0]),
    .byte_i (wdata_q),
    .byte_o (lane_byte),
    .word_o (lane_word)
  );

`ifdef SDRAM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // round-robin pointer, starts on client 0
  always_ff @(posedge sdram_clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  // pointer client wins a tie; flip after every grant
  always_comb begin
    pick  = (c0_req && c1_req) ? ptr_q : c1_req;
    ptr_d = ptr_q;
    if (state_q == IDLE && (c0_req || c1_req)) ptr_d = ~pick;
  end
`else
  // client 0 (PPU) wins every tie
  always_comb pick = !c0_req;
`endif

  // state and datapath registers
  always_ff @(posedge sdram_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      wword_q <= '0;
      cap_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      wword_q <= wword_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  // next state, controller handshake and client acks
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    wword_d      = wword_q;
    cap_d        = cap_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rd0_d        = rd0_q;
    rd1_d        = rd1_q;
    ctl_in_valid = 1'b0;
    ctl_rw       = 1'b0;
    c0_ack       = 1'b0;
    c1_ack       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c0_req || c1_req) begin
          gnt_d   = pick;
          we_d    = pick ? c1_we    : c0_we;
          addr_d  = pick ? c1_addr  : c0_addr;
          wdata_d = pick ? c1_wdata : c0_wdata;
          cap_d   = 1'b0;
          cnt_d   = '0;
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        ctl_in_valid = !ctl_busy;
        if (!ctl_busy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cap_q) begin
          if (we_q) begin
            wword_d = lane_word;
            state_d = WR_ISSUE;
          end else begin
            if (gnt_q) rd1_d = lane_byte;
            else       rd0_d = lane_byte;
            state_d = ACK;
          end
        end else if (ctl_out_valid) begin
          word_d = ctl_rdata;
          cap_d  = 1'b1;
        end else if (cnt_q == TO_W'(RD_TIMEOUT - 1)) begin
          err_d = 1'b1;
          if (!we_q) begin
            if (gnt_q) rd1_d = 8'hFF;
            else       rd0_d = 8'hFF;
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_ISSUE: begin
        ctl_rw       = 1'b1;
        ctl_in_valid = !ctl_busy;
        if (!ctl_busy) state_d = ACK;
      end
      ACK: begin
        c0_ack  = !gnt_q;
        c1_ack  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctl_addr  = addr_q[23:2];
  assign ctl_wdata = wword_q;
  assign c0_rdata  = rd0_q;
  assign c1_rdata  = rd1_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sdram_byte_arbiter.sv
// Bench for sdram_byte_arbiter: vector table, scoreboard on acks,
// plus busy, timeout, arbitration and reset sequences.
module tb_sdram_byte_arbiter;
  import sdram_arb_pkg::*;

  logic        sdram_clk, rst_n;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [23:0] c0_addr, c1_addr;
  logic [7:0]  c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic        c0_ack, c1_ack;
  logic [21:0] ctl_addr;
  logic        ctl_rw, ctl_in_valid, ctl_busy, ctl_out_valid, err;
  logic [31:0] ctl_wdata, ctl_rdata;

  sdram_byte_arbiter #(.RD_TIMEOUT(255)) dut (
    .sdram_clk(sdram_clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_rdata(c0_rdata), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr),
    .c1_wdata(c1_wdata), .c1_rdata(c1_rdata), .c1_ack(c1_ack),
    .ctl_addr(ctl_addr), .ctl_rw(ctl_rw), .ctl_wdata(ctl_wdata),
    .ctl_in_valid(ctl_in_valid), .ctl_busy(ctl_busy),
    .ctl_rdata(ctl_rdata), .ctl_out_valid(ctl_out_valid), .err(err)
  );

  typedef struct {
    bit          cl;
    bit          chk;
    logic [7:0]  rd;
  } exp_t;

  typedef struct {
    bit          cl;
    bit          we;
    logic [23:0] addr;
    logic [7:0]  wd;
    logic [31:0] mem;
    logic [21:0] wa;
    logic [31:0] ww;
    logic [7:0]  rd;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[7];
  logic [31:0] mem [logic [21:0]];
  int checks = 0, errors = 0;
  int cyc = 0, acc_cnt = 0, wr_cnt = 0, ack_cnt = 0, viol = 0;
  int rcnt = 0, rd_lat = 1;
  bit rsp_en = 1;
  int ov_cyc = 0, ra_cyc = 0, wr_cyc = 0, ack_cyc = 0, req_cyc = 0;
  logic [21:0] ra, wa;
  logic [31:0] ww, rdat;

  initial begin
    sdram_clk = 0;
    forever #5 sdram_clk = ~sdram_clk;
  end

  initial forever begin
    @(posedge sdram_clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // controller model and ack scoreboard, sampled mid-cycle
  initial forever begin
    @(negedge sdram_clk);
    ctl_out_valid = 0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        ctl_out_valid = 1;
        ctl_rdata = rdat;
        ov_cyc = cyc;
      end
    end
    if (ctl_in_valid && ctl_busy) viol++;
    if (ctl_in_valid && !ctl_busy) begin
      acc_cnt++;
      if (ctl_rw) begin
        wr_cnt++;
        wa = ctl_addr;
        ww = ctl_wdata;
        wr_cyc = cyc;
        mem[ctl_addr] = ctl_wdata;
      end else begin
        ra = ctl_addr;
        ra_cyc = cyc;
        if (rsp_en) begin
          rcnt = rd_lat;
          rdat = mem.exists(ctl_addr) ? mem[ctl_addr] : 32'h0;
        end
      end
    end
    if (c0_ack || c1_ack) begin
      exp_t e;
      logic [7:0] got;
      ack_cnt++;
      ack_cyc = cyc;
      checks++;
      got = c1_ack ? c1_rdata : c0_rdata;
      if (c0_ack && c1_ack) begin
        errors++;
        $display("FAIL ack_both: c0_ack=1 c1_ack=1 expected one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: client %0d acked, none expected",
                 c1_ack);
      end else begin
        e = sb.pop_front();
        if (c1_ack !== e.cl || (e.chk && got !== e.rd)) begin
          errors++;
          $display("FAIL ack_sb: client %0d rdata %h expected client %0d rdata %h",
                   c1_ack, got, e.cl, e.rd);
        end
      end
    end
  end

  task automatic issue(input bit cl, input bit we, input logic [23:0] a,
                       input logic [7:0] wd, input bit push,
                       input logic [7:0] rd, input bit chkrd);
    exp_t e;
    @(posedge sdram_clk); #1;
    req_cyc = cyc;
    if (cl) begin
      c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = wd;
    end else begin
      c0_req = 1; c0_we = we; c0_addr = a; c0_wdata = wd;
    end
    if (push) begin
      e.cl = cl; e.chk = chkrd; e.rd = rd;
      sb.push_back(e);
    end
  endtask

  task automatic wait_ack(input int budget, input string nm, input bit drop);
    int a0 = ack_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge sdram_clk);
      if (ack_cnt != a0) break;
    end
    chk({nm, "_ack_seen"}, 32'(ack_cnt != a0), 32'd1);
    if (drop) begin
      #1; c0_req = 0; c1_req = 0;
    end
  endtask

  task automatic do_reset;
    @(posedge sdram_clk); #1;
    rst_n = 0; c0_req = 0; c1_req = 0;
    repeat (3) @(posedge sdram_clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_flags"}, 32'({c0_ack, c1_ack, ctl_in_valid, ctl_rw, err}), 0);
    chk({nm, "_addr"}, 32'(ctl_addr), 0);
    chk({nm, "_wdata"}, ctl_wdata, 0);
    chk({nm, "_rdata"}, 32'({c0_rdata, c1_rdata}), 0);
    chk({nm, "_state"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  initial begin
    int a0, w0;
    rst_n = 0; c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0;
    c0_addr = 0; c1_addr = 0; c0_wdata = 0; c1_wdata = 0;
    ctl_busy = 0; ctl_rdata = 0; ctl_out_valid = 0;

    vt[0] = '{1, 0, 24'h000007, 8'h00, 32'hAABBCCDD, 22'h000001, 32'h0, 8'hAA};
    vt[1] = '{0, 1, 24'h000102, 8'h5A, 32'h11223344, 22'h000040, 32'h115A3344, 8'h0};
    vt[2] = '{0, 0, 24'h000100, 8'h00, 32'h87654321, 22'h000040, 32'h0, 8'h21};
    vt[3] = '{1, 1, 24'h000005, 8'hC3, 32'h00000000, 22'h000001, 32'h0000C300, 8'h0};
    vt[4] = '{1, 0, 24'h000006, 8'h00, 32'hDEADBEEF, 22'h000001, 32'h0, 8'hAD};
    vt[5] = '{0, 1, 24'h000FFF, 8'h01, 32'hFFFFFFFF, 22'h0003FF, 32'h01FFFFFF, 8'h0};
    vt[6] = '{0, 0, 24'hFFFFFD, 8'h00, 32'h01234567, 22'h3FFFFF, 32'h0, 8'h45};

    do_reset();
    chk_reset_outs("reset");
    rst_n = 1;

    foreach (vt[i]) begin
      mem[vt[i].wa] = vt[i].mem;
      w0 = wr_cnt;
      issue(vt[i].cl, vt[i].we, vt[i].addr, vt[i].wd, 1, vt[i].rd, !vt[i].we);
      wait_ack(50, $sformatf("vec%0d", i), 1);
      chk($sformatf("vec%0d_rd_addr", i), 32'(ra), 32'(vt[i].wa));
      chk($sformatf("vec%0d_iss_lat", i), ra_cyc - req_cyc, 1);
      if (vt[i].we) begin
        chk($sformatf("vec%0d_wr_cnt", i), wr_cnt - w0, 1);
        chk($sformatf("vec%0d_wr_addr", i), 32'(wa), 32'(vt[i].wa));
        chk($sformatf("vec%0d_wr_word", i), ww, vt[i].ww);
        chk($sformatf("vec%0d_wr_lat", i), ack_cyc - wr_cyc, 1);
      end else begin
        chk($sformatf("vec%0d_wr_cnt", i), wr_cnt - w0, 0);
        chk($sformatf("vec%0d_rd_lat", i), ack_cyc - ov_cyc, 2);
      end
    end

    // simultaneous requests held through four grants
    mem[22'h000010] = 32'h00000011;
    mem[22'h000020] = 32'h00000022;
`ifdef SDRAM_ARB_RR_EN
    sb.push_back('{0, 1, 8'h11}); sb.push_back('{1, 1, 8'h22});
    sb.push_back('{0, 1, 8'h11}); sb.push_back('{1, 1, 8'h22});
`else
    for (int k = 0; k < 4; k++) sb.push_back('{0, 1, 8'h11});
`endif
    @(posedge sdram_clk); #1;
    c0_req = 1; c0_we = 0; c0_addr = 24'h000040;
    c1_req = 1; c1_we = 0; c1_addr = 24'h000080;
    for (int k = 0; k < 4; k++)
      wait_ack(50, $sformatf("arb%0d", k), k == 3);
    chk("arb_sb_empty", sb.size(), 0);

    // controller busy at issue
    mem[22'h000011] = 32'h12345678;
    ctl_busy = 1;
    a0 = acc_cnt;
    issue(0, 0, 24'h000044, 8'h00, 1, 8'h78, 1);
    repeat (10) @(posedge sdram_clk);
    #1;
    chk("busy_no_accept", acc_cnt - a0, 0);
    ctl_busy = 0;
    w0 = cyc;
    wait_ack(50, "busy", 1);
    chk("busy_accept_cyc", ra_cyc, w0);
    chk("busy_one_accept", acc_cnt - a0, 1);
    chk("busy_no_viol", viol, 0);

    // read timeout: no ctl_out_valid
    rsp_en = 0;
    issue(1, 0, 24'h000123, 8'h00, 1, 8'hFF, 1);
    wait_ack(400, "to_rd", 1);
    chk("to_rd_lat", ack_cyc - ra_cyc, 256);
    chk("to_err", 32'(err), 1);
    w0 = wr_cnt;
    issue(0, 1, 24'h000123, 8'h77, 1, 8'h00, 0);
    wait_ack(400, "to_wr", 1);
    chk("to_wr_aborted", wr_cnt - w0, 0);
    rsp_en = 1;
    issue(0, 0, 24'h000044, 8'h00, 1, 8'h78, 1);
    wait_ack(50, "err_sticky_rd", 1);
    chk("err_sticky", 32'(err), 1);

    // reset during RD_WAIT, late read data
    rd_lat = 20;
    issue(1, 0, 24'h000044, 8'h00, 0, 8'h00, 0);
    repeat (5) @(posedge sdram_clk);
    #1;
    chk("rst_in_wait", 32'(dut.state_q), 32'(RD_WAIT));
    a0 = ack_cnt;
    rst_n = 0; c1_req = 0;
    repeat (2) @(posedge sdram_clk);
    #1;
    rst_n = 1;
    repeat (30) @(posedge sdram_clk);
    #1;
    chk("rst_no_ack", ack_cnt - a0, 0);
    chk_reset_outs("rst_mid");
    rd_lat = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
